// File: rtl/mem_atomic_pkg.sv
// Shared types and helpers for the data-memory responder and its reservation monitor.
package mem_atomic_pkg;

  localparam int WORD_W        = 32;
  localparam int DEPTH_DEFAULT = 64;

  // Byte address to word index. Callers truncate the result to their own index width,
  // so upper address bits wrap modulo the memory depth.
  function automatic logic [WORD_W-1:0] word_idx(input logic [WORD_W-1:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/resv_monitor.sv
// Load-link reservation tracker. Holds a single reservation, judges store-conditional
// success combinationally and clears the reservation on any conflicting write.
module resv_monitor
  import mem_atomic_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ll,
  input  logic             sc,
  input  logic             plain_we,
  input  logic             snoop_we,
  input  logic [IDX_W-1:0] core_idx,
  input  logic [IDX_W-1:0] snoop_idx,
  output logic             sc_ok
);

  logic             r_resvValid;
  logic [IDX_W-1:0] r_resvIdx;
  logic             w_snoopHitsCore;
  logic             w_coreHitsResv;
  logic             w_snoopHitsResv;

  assign w_snoopHitsCore = snoop_we & (snoop_idx == core_idx);
  assign w_coreHitsResv  = plain_we & (core_idx == r_resvIdx);
  assign w_snoopHitsResv = snoop_we & (snoop_idx == r_resvIdx);

  // A concurrent snoop write to the same word beats the sc, so it must fail.
  assign sc_ok = sc & ~reset & r_resvValid & (r_resvIdx == core_idx) & ~w_snoopHitsCore;

  // Reservation update: reset, then any sc consumes it, then ll arms it, then conflicting writes kill it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_resvValid <= 1'b0;
      r_resvIdx   <= '0;
    end else if (sc) begin
      r_resvValid <= 1'b0;
    end else if (ll) begin
      r_resvIdx   <= core_idx;
      r_resvValid <= ~w_snoopHitsCore;
    end else if (w_coreHitsResv | w_snoopHitsResv) begin
      r_resvValid <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_atomic_responder.sv
// Data-memory responder for the single-cycle MIPS core: word memory with combinational
// read, ll/sc atomics through resv_monitor, a snoop write port and saturating sc statistics.
module dmem_atomic_responder
  import mem_atomic_pkg::*;
#(
  parameter int    DEPTH     = DEPTH_DEFAULT,
  parameter int    CNT_W     = 16,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] wd,
  input  logic              memwrite,
  input  logic              ll,
  input  logic              sc,
  output logic [WORD_W-1:0] rd,
  output logic              sc_ok,
  input  logic              snoop_we,
  input  logic [WORD_W-1:0] snoop_a,
  input  logic [WORD_W-1:0] snoop_wd,
  output logic [CNT_W-1:0]  sc_pass_cnt,
  output logic [CNT_W-1:0]  sc_fail_cnt
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_passCnt;
  logic [CNT_W-1:0]  r_failCnt;
  logic [IDX_W-1:0]  w_coreIdx;
  logic [IDX_W-1:0]  w_snoopIdx;
  logic              w_plainWe;
  logic              w_coreWe;

  assign w_coreIdx  = IDX_W'(word_idx(a));
  assign w_snoopIdx = IDX_W'(word_idx(snoop_a));

  // A failed sc never writes, whatever memwrite says; reset blocks all core stores.
  assign w_plainWe = memwrite & ~sc & ~reset;
  assign w_coreWe  = w_plainWe | (sc & sc_ok);

  assign rd          = r_mem[w_coreIdx];
  assign sc_pass_cnt = r_passCnt;
  assign sc_fail_cnt = r_failCnt;

  resv_monitor #(
    .IDX_W (IDX_W)
  ) u_resvMonitor (
    .clk       (clk),
    .reset     (reset),
    .ll        (ll),
    .sc        (sc),
    .plain_we  (w_plainWe),
    .snoop_we  (snoop_we),
    .core_idx  (w_coreIdx),
    .snoop_idx (w_snoopIdx),
    .sc_ok     (sc_ok)
  );

  // Memory writes; the snoop write comes last so its data lands on a same-word collision.
  always_ff @(posedge clk) begin
    if (w_coreWe) begin
      r_mem[w_coreIdx] <= wd;
    end
    if (snoop_we) begin
      r_mem[w_snoopIdx] <= snoop_wd;
    end
  end

  // Saturating sc pass/fail statistics, one increment per sc cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_passCnt <= '0;
      r_failCnt <= '0;
    end else if (sc) begin
      if (sc_ok) begin
        if (r_passCnt != '1) r_passCnt <= r_passCnt + 1'b1;
      end else begin
        if (r_failCnt != '1) r_failCnt <= r_failCnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_atomic_responder.sv
// Directed bench for dmem_atomic_responder: ll/sc success and failure paths, snoop
// interference, reset of the reservation, address wrap and counter saturation.
module tb_dmem_atomic_responder;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] wd;
  logic        memwrite;
  logic        ll;
  logic        sc;
  logic [31:0] rd;
  logic        sc_ok;
  logic        snoop_we;
  logic [31:0] snoop_a;
  logic [31:0] snoop_wd;
  logic [3:0]  sc_pass_cnt;
  logic [3:0]  sc_fail_cnt;

  int checkCount = 0;
  int passCount  = 0;

  // Small counters so saturation is reachable with a handful of sc cycles.
  dmem_atomic_responder #(
    .DEPTH (64),
    .CNT_W (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .a           (a),
    .wd          (wd),
    .memwrite    (memwrite),
    .ll          (ll),
    .sc          (sc),
    .rd          (rd),
    .sc_ok       (sc_ok),
    .snoop_we    (snoop_we),
    .snoop_a     (snoop_a),
    .snoop_wd    (snoop_wd),
    .sc_pass_cnt (sc_pass_cnt),
    .sc_fail_cnt (sc_fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's worth of core and snoop inputs.
  task automatic applyStimulus(input logic iReset, input logic [31:0] iA, input logic [31:0] iWd,
                               input logic iMemwrite, input logic iLl, input logic iSc,
                               input logic iSnoopWe, input logic [31:0] iSnoopA,
                               input logic [31:0] iSnoopWd);
    reset    = iReset;
    a        = iA;
    wd       = iWd;
    memwrite = iMemwrite;
    ll       = iLl;
    sc       = iSc;
    snoop_we = iSnoopWe;
    snoop_a  = iSnoopA;
    snoop_wd = iSnoopWd;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Let the current inputs be clocked in, then return to the falling edge to drive again.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Idle the core on an address so rd shows that word.
  task automatic readWord(input logic [31:0] addr);
    applyStimulus(1'b0, addr, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
  endtask

  initial begin
    @(negedge clk);

    // Reset: sc asserted during reset must neither succeed nor count.
    applyStimulus(1'b1, 32'h40, 32'h1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("sc_ok_in_reset", {31'h0, sc_ok}, 32'h0);
    cycle();
    checkOutput("reset_pass_cnt", {28'h0, sc_pass_cnt}, 32'h0);
    checkOutput("reset_fail_cnt", {28'h0, sc_fail_cnt}, 32'h0);

    // Preload mem[0x10]=5, mem[0x11]=0x11, mem[0]=0xAA through plain stores.
    applyStimulus(1'b0, 32'h40, 32'h5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
    applyStimulus(1'b0, 32'h44, 32'h11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
    applyStimulus(1'b0, 32'h0, 32'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle();

    // Case 1: ll reads 5, sc succeeds and writes 6.
    applyStimulus(1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("t1_ll_rd", rd, 32'h5);
    cycle();
    applyStimulus(1'b0, 32'h40, 32'h6, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("t1_sc_ok", {31'h0, sc_ok}, 32'h1);
    cycle();
    readWord(32'h40);
    checkOutput("t1_mem", rd, 32'h6);
    checkOutput("t1_pass_cnt", {28'h0, sc_pass_cnt}, 32'h1);

    // Case 2: an intervening plain store kills the reservation.
    applyStimulus(1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
    applyStimulus(1'b0, 32'h40, 32'h7, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
    applyStimulus(1'b0, 32'h40, 32'h8, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("t2_sc_ok", {31'h0, sc_ok}, 32'h0);
    cycle();
    readWord(32'h40);
    checkOutput("t2_mem", rd, 32'h7);
    checkOutput("t2_fail_cnt", {28'h0, sc_fail_cnt}, 32'h1);

    // Case 3: an intervening snoop write kills the reservation.
    applyStimulus(1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
    applyStimulus(1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h9);
    cycle();
    applyStimulus(1'b0, 32'h40, 32'h8, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("t3_sc_ok", {31'h0, sc_ok}, 32'h0);
    cycle();
    readWord(32'h40);
    checkOutput("t3_mem", rd, 32'h9);

    // Case 4: sc to another word fails and consumes the reservation.
    applyStimulus(1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
    applyStimulus(1'b0, 32'h44, 32'h3, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("t4_sc_other_ok", {31'h0, sc_ok}, 32'h0);
    cycle();
    applyStimulus(1'b0, 32'h40, 32'h4, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("t4_sc_again_ok", {31'h0, sc_ok}, 32'h0);
    cycle();
    readWord(32'h44);
    checkOutput("t4_mem_other", rd, 32'h11);
    readWord(32'h40);
    checkOutput("t4_mem_resv", rd, 32'h9);
    checkOutput("t4_fail_cnt", {28'h0, sc_fail_cnt}, 32'h4);

    // Case 5: reset between ll and sc drops the reservation and clears counters.
    applyStimulus(1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
    applyStimulus(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
    checkOutput("t5_pass_cnt_rst", {28'h0, sc_pass_cnt}, 32'h0);
    checkOutput("t5_fail_cnt_rst", {28'h0, sc_fail_cnt}, 32'h0);
    applyStimulus(1'b0, 32'h40, 32'hA, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("t5_sc_ok", {31'h0, sc_ok}, 32'h0);
    cycle();
    readWord(32'h40);
    checkOutput("t5_mem", rd, 32'h9);
    checkOutput("t5_fail_cnt", {28'h0, sc_fail_cnt}, 32'h1);

    // Case 6: snoop to the same word in the sc cycle wins; snoop data lands.
    applyStimulus(1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
    applyStimulus(1'b0, 32'h40, 32'h1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h2);
    #1;
    checkOutput("t6_sc_ok", {31'h0, sc_ok}, 32'h0);
    cycle();
    readWord(32'h40);
    checkOutput("t6_mem", rd, 32'h2);
    checkOutput("t6_fail_cnt", {28'h0, sc_fail_cnt}, 32'h2);

    // Address decode: byte offset ignored, upper bits wrap modulo depth.
    readWord(32'h43);
    checkOutput("addr_byte_offset", rd, 32'h2);
    readWord(32'h140);
    checkOutput("addr_wrap", rd, 32'h2);

    // ll with a same-cycle snoop hit never arms the reservation.
    applyStimulus(1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h3);
    cycle();
    applyStimulus(1'b0, 32'h40, 32'h4, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("ll_snoop_sc_ok", {31'h0, sc_ok}, 32'h0);
    cycle();
    readWord(32'h40);
    checkOutput("ll_snoop_mem", rd, 32'h3);

    // A second ll replaces the first reservation.
    applyStimulus(1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
    applyStimulus(1'b0, 32'h44, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
    applyStimulus(1'b0, 32'h44, 32'h55, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("ll_replace_sc_ok", {31'h0, sc_ok}, 32'h1);
    cycle();
    readWord(32'h44);
    checkOutput("ll_replace_mem", rd, 32'h55);
    checkOutput("ll_replace_pass", {28'h0, sc_pass_cnt}, 32'h1);
    checkOutput("ll_replace_fail", {28'h0, sc_fail_cnt}, 32'h3);

    // Drive the fail counter from 3 to 15 with unreserved sc, then one more must hold it.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 32'h0, 32'hBAD, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      cycle();
    end
    checkOutput("sat_reach", {28'h0, sc_fail_cnt}, 32'hF);
    applyStimulus(1'b0, 32'h0, 32'hBAD, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    cycle();
    checkOutput("sat_hold", {28'h0, sc_fail_cnt}, 32'hF);
    checkOutput("sat_pass_cnt", {28'h0, sc_pass_cnt}, 32'h1);
    readWord(32'h0);
    checkOutput("failed_sc_no_write", rd, 32'hAA);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
